kick_sequencer: RTL and testbench
=================================

# kick_sequencer

Initiator side of the kicker-solenoid interface. It takes kick requests from the robot's main control FSM and fires the solenoid pulse block through its rising-edge `Enable` input. It only fires when the system is armed and a debounced ball-present sensor says a ball is in the kicker. It enforces a solenoid cooldown between kicks and reports completion, rejection and a running kick count back to the controller.

## Interface
Parameters:
- `ENABLE_CYCLES`, default 4: cycles `Enable` is held high per kick (≥1).
- `KICK_CYCLES`, default 10: cycles waited after `Enable` falls, covering the solenoid pulse plus margin (≥1).
- `COOLDOWN_CYCLES`, default 50_000_000: recharge lockout after each kick or abort (≥1).
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples needed to change `BallPresent` (≥1).

Ports:
- `clk`, in, 1: single system clock.
- `Reset`, in, 1: synchronous, active-high reset.
- `Req`, in, 1: kick request level, synchronous to `clk`; only its rising edge matters.
- `Arm`, in, 1: system arm; kicks are permitted only while it is high.
- `BallSense`, in, 1: raw, asynchronous ball sensor; high means a ball is present.
- `Enable`, out, 1: drives the kicker's `Enable` input; registered.
- `Ready`, out, 1: high while the block is idle, armed and `BallPresent` is 1.
- `Done`, out, 1: one-cycle pulse when a kick completes.
- `Reject`, out, 1: one-cycle pulse when a `Req` edge is refused.
- `BallPresent`, out, 1: debounced ball state.
- `KickCount`, out, 8: completed kicks, wrapping 255→0.

## Operation
Ball sensor:
- `BallSense` passes through a 2-FF synchronizer.
- `BallPresent` takes the synchronized value after it differs from `BallPresent` for `DEBOUNCE_CYCLES` consecutive cycles.
- Any sample equal to `BallPresent` clears the debounce counter.

Request edge:
- `Req` is registered into `Req_q`. An edge is `Req & ~Req_q`.
- `Req_q` resets to 1, so a request held high through reset does not fire.

State machine (IDLE, FIRE, WAIT, COOLDOWN):
- **IDLE**
  - Edge with `Arm`=1 and `BallPresent`=1: go to FIRE, load the counter, set `Enable`=1.
  - Edge otherwise: `Reject` pulses and the state stays IDLE.
- **FIRE**
  - `Enable`=1 for `ENABLE_CYCLES` cycles, then go to WAIT with `Enable`=0.
  - If `Arm` is sampled 0 in FIRE: clear `Enable` at that edge and go to COOLDOWN. No `Done`, no count increment.
- **WAIT**
  - Lasts `KICK_CYCLES` cycles, then go to COOLDOWN, pulse `Done` and increment `KickCount`.
  - `Arm` falling here is ignored; the pulse is already committed.
- **COOLDOWN**
  - Lasts `COOLDOWN_CYCLES` cycles, then go to IDLE. Ignores `Arm`.

Requests outside IDLE:
- Any `Req` edge in FIRE, WAIT or COOLDOWN pulses `Reject`.
- Requests are never queued.

Sizing and output rules:
- One shared down-counter, sized `$clog2` of the largest cycle parameter plus 1.
- `Ready` is combinational from the state and the registered `Arm`/`BallPresent` terms, glitch-free per cycle.
- `Done` and `Reject` are never high in the same cycle.

## Timing
- Reset values: `Enable`=0, `Ready`=0, `Done`=0, `Reject`=0, `BallPresent`=0, `KickCount`=0, state IDLE, counters 0, synchronizer flops 0.
- Reset mid-operation: state returns to IDLE and `Enable` drops at the same edge. No `Done` and no cooldown are owed afterwards.
- Kick sequence, with accept edge E:
  - `Enable` is high in cycles E+1 … E+`ENABLE_CYCLES`.
  - WAIT occupies the next `KICK_CYCLES` cycles.
  - `Done` is high in the first COOLDOWN cycle.
  - `Ready` returns `COOLDOWN_CYCLES` cycles after that.
- `Reject` is high in the cycle after the offending edge.
- Ball sensor latency: a change on `BallSense` reaches `BallPresent` 2 + `DEBOUNCE_CYCLES` cycles later, ±1 cycle.
- `Enable` is a single clean high window per kick. The minimum low gap between kicks is `KICK_CYCLES` + `COOLDOWN_CYCLES` + 1.

## Test plan
All scenarios use `ENABLE_CYCLES`=2, `KICK_CYCLES`=10, `COOLDOWN_CYCLES`=20, `DEBOUNCE_CYCLES`=4.

- **Nominal kick:** `Arm`=1, ball held, `Req` rises at E → `Enable` high in E+1..E+2, `Done` high in E+13, `KickCount`=1, `Ready` high again at E+33.
- **No ball or disarmed:** `BallSense`=0 (or `Arm`=0), `Req` edge → `Reject` high 1 cycle, `Enable` never rises, `KickCount` unchanged.
- **Busy rejection:** `Req` edge during WAIT and again during COOLDOWN → two `Reject` pulses, exactly one `Done`, no second `Enable` window.
- **Abort:** `Arm` drops in the second FIRE cycle → `Enable` low at that edge, no `Done`, `KickCount` unchanged, `Ready` held low for 20 cycles.
- **Debounce:** `BallSense` toggles with a 3-cycle period → `BallPresent` stays 0. Held high for 6+ cycles → `BallPresent`=1.
- **Reset and wrap:** `Reset` asserted mid-WAIT while `Req` stays high → `Enable`=0, no spurious kick after release. 256 nominal kicks → `KickCount` wraps to 0.

Source files
------------

// File: rtl/kick_sequencer.sv
// kick_sequencer: fires the kicker solenoid through a rising-edge Enable
// window when armed with a debounced ball present, then holds off for a
// recharge cooldown. Reports Done/Reject pulses and a wrapping kick count.
//
// Handshake: Req is a level whose rising edge is one request. Each edge
// gets exactly one answer: a kick (Enable window, later Done) or a one-cycle
// Reject. Requests are never queued. Done and Reject never coincide; a
// Reject that would collide with Done is delivered one cycle later.
module kick_sequencer #(
  parameter int ENABLE_CYCLES   = 4,
  parameter int KICK_CYCLES     = 10,
  parameter int COOLDOWN_CYCLES = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Req,
  input  logic       Arm,
  input  logic       BallSense,
  output logic       Enable,
  output logic       Ready,
  output logic       Done,
  output logic       Reject,
  output logic       BallPresent,
  output logic [7:0] KickCount
);

  localparam int MAX_EK  = (ENABLE_CYCLES > KICK_CYCLES) ? ENABLE_CYCLES : KICK_CYCLES;
  localparam int MAX_ALL = (MAX_EK > COOLDOWN_CYCLES) ? MAX_EK : COOLDOWN_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CW-1:0] EN_LOAD = CW'(ENABLE_CYCLES - 1);
  localparam logic [CW-1:0] KC_LOAD = CW'(KICK_CYCLES - 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, COOLDOWN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          req_q;
  logic          arm_q;
  logic          sync1;
  logic          sync2;
  logic [DW-1:0] db_cnt;
  logic          rej_pend;
  logic          req_edge;

  assign req_edge = Req & ~req_q;

  // Idle, armed and holding a ball: the controller may request a kick.
  assign Ready = (state == IDLE) && arm_q && BallPresent;

  // Synchronize the raw ball sensor and debounce it into BallPresent.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      db_cnt      <= '0;
      BallPresent <= 1'b0;
    end else begin
      sync1 <= BallSense;
      sync2 <= sync1;
      if (sync2 == BallPresent) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        BallPresent <= sync2;
        db_cnt      <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  // Register Req for edge detection (reset high so a held request is not an
  // edge) and Arm for the Ready term.
  always_ff @(posedge clk) begin
    if (Reset) begin
      req_q <= 1'b1;
      arm_q <= 1'b0;
    end else begin
      req_q <= Req;
      arm_q <= Arm;
    end
  end

  // Kick sequencing FSM with one shared down-counter and registered outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      Enable    <= 1'b0;
      Done      <= 1'b0;
      Reject    <= 1'b0;
      rej_pend  <= 1'b0;
      KickCount <= '0;
    end else begin
      Done     <= 1'b0;
      Reject   <= rej_pend;
      rej_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (req_edge) begin
            if (Arm && BallPresent) begin
              state  <= FIRE;
              cnt    <= EN_LOAD;
              Enable <= 1'b1;
            end else begin
              Reject <= 1'b1;
            end
          end
        end
        FIRE: begin
          if (req_edge) Reject <= 1'b1;
          if (!Arm) begin
            // Abort: drop Enable now, still pay the recharge lockout.
            state  <= COOLDOWN;
            cnt    <= CD_LOAD;
            Enable <= 1'b0;
          end else if (cnt == '0) begin
            state  <= WAIT;
            cnt    <= KC_LOAD;
            Enable <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= COOLDOWN;
            cnt       <= CD_LOAD;
            Done      <= 1'b1;
            KickCount <= KickCount + 8'd1;
            // Push a coinciding Reject one cycle out so it never overlaps Done.
            if (req_edge) rej_pend <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
            if (req_edge) Reject <= 1'b1;
          end
        end
        COOLDOWN: begin
          if (req_edge) Reject <= 1'b1;
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          Enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kick_sequencer.sv
// tb_kick_sequencer: drives kick_sequencer with directed scenarios and a
// randomized phase, comparing every cycle's outputs against a timeline model
// built from kick accept times, lockout end times and a sensor-window rule.
module tb_kick_sequencer;

  localparam int EN   = 2;
  localparam int KC   = 10;
  localparam int CD   = 20;
  localparam int DB   = 4;
  localparam int NCYC = 16384;

  // ---------------- clock / reset block ----------------
  logic       clk = 1'b0;
  logic       Reset;
  logic       Req;
  logic       Arm;
  logic       BallSense;
  logic       Enable;
  logic       Ready;
  logic       Done;
  logic       Reject;
  logic       BallPresent;
  logic [7:0] KickCount;

  always #5 clk = ~clk;

  kick_sequencer #(
    .ENABLE_CYCLES  (EN),
    .KICK_CYCLES    (KC),
    .COOLDOWN_CYCLES(CD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Req        (Req),
    .Arm        (Arm),
    .BallSense  (BallSense),
    .Enable     (Enable),
    .Ready      (Ready),
    .Done       (Done),
    .Reject     (Reject),
    .BallPresent(BallPresent),
    .KickCount  (KickCount)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int n      = 0;
  logic [12:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-cycle input history; the model reasons in absolute cycle numbers.
  bit raw_h [NCYC];
  bit rst_h [NCYC];
  bit req_h [NCYC];
  bit s2_h  [NCYC];

  bit         kick_valid = 1'b0;
  bit         aborted    = 1'b0;
  bit         m_bp       = 1'b0;
  bit         rej_pend   = 1'b0;
  int         e_cyc      = 0;
  int         busy_end   = 0;
  logic [7:0] m_cnt      = 8'd0;

  // Given this cycle's inputs, predict the outputs of the next cycle.
  task automatic model_step();
    bit s2, req_prev, req_edge, idle, en, dn, rj, rj_ev, rdy, all_diff;
    raw_h[n] = BallSense;
    rst_h[n] = Reset;
    req_h[n] = Req;
    s2 = 1'b0;
    if (n >= 2) begin
      if (!rst_h[n-1] && !rst_h[n-2]) s2 = raw_h[n-2];
    end
    s2_h[n] = s2;
    if (Reset) begin
      kick_valid = 1'b0;
      aborted    = 1'b0;
      m_bp       = 1'b0;
      rej_pend   = 1'b0;
      m_cnt      = 8'd0;
      exp_q.push_back(13'd0);
    end else begin
      req_prev = 1'b1;
      if (n >= 1) begin
        if (!rst_h[n-1]) req_prev = req_h[n-1];
      end
      req_edge = Req && !req_prev;
      idle     = !kick_valid || (n >= busy_end);
      en = 1'b0; dn = 1'b0; rj_ev = 1'b0;
      // Arm low during the Enable window aborts the kick into a lockout.
      if (kick_valid && !aborted && n >= e_cyc + 1 && n <= e_cyc + EN && !Arm) begin
        aborted  = 1'b1;
        busy_end = n + 1 + CD;
      end
      if (kick_valid && !aborted) begin
        en = (n + 1 <= e_cyc + EN);
        dn = (n + 1 == e_cyc + EN + KC + 1);
      end
      if (dn) m_cnt = m_cnt + 8'd1;
      if (req_edge) begin
        if (idle && Arm && m_bp) begin
          e_cyc      = n;
          kick_valid = 1'b1;
          aborted    = 1'b0;
          busy_end   = n + EN + KC + CD + 1;
          en         = 1'b1;
        end else begin
          rj_ev = 1'b1;
        end
      end
      rj       = rej_pend || (rj_ev && !dn);
      rej_pend = rj_ev && dn;
      // Ball state flips once DB consecutive synchronized samples disagree.
      if (n >= DB - 1) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) if (s2_h[n-k] == m_bp) all_diff = 1'b0;
        if (all_diff) m_bp = !m_bp;
      end
      rdy = (!kick_valid || (n + 1 >= busy_end)) && Arm && m_bp;
      exp_q.push_back({en, dn, rj, m_bp, rdy, m_cnt});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [12:0] e;
    if (n >= NCYC - 1) begin
      $display("FAIL cycle_budget cycle=%0d got=over expected=under %0d", n, NCYC);
      $fatal(1, "cycle budget exhausted");
    end
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("enable",       {15'd0, Enable},      {15'd0, e[12]});
    check("done",         {15'd0, Done},        {15'd0, e[11]});
    check("reject",       {15'd0, Reject},      {15'd0, e[10]});
    check("ball_present", {15'd0, BallPresent}, {15'd0, e[9]});
    check("ready",        {15'd0, Ready},       {15'd0, e[8]});
    check("kick_count",   {8'd0, KickCount},    {8'd0, e[7:0]});
    n++;
  endtask

  task automatic kick_pulse();
    Req = 1'b1;
    tick();
    Req = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; Req = 1'b0; Arm = 1'b0; BallSense = 1'b0;
    repeat (3) tick();
    Reset = 1'b0; Arm = 1'b1; BallSense = 1'b1;
    repeat (10) tick();

    // Nominal kick
    kick_pulse();
    repeat (40) tick();
    check("nominal_count", {8'd0, KickCount}, 16'd1);

    // Busy rejections: one edge in WAIT, one in COOLDOWN
    Req = 1'b1; tick();
    Req = 1'b0; repeat (4) tick();
    Req = 1'b1; tick();
    Req = 1'b0; repeat (12) tick();
    Req = 1'b1; tick();
    Req = 1'b0; repeat (25) tick();
    check("busy_count", {8'd0, KickCount}, 16'd2);

    // Disarmed, then no ball
    Arm = 1'b0; kick_pulse(); repeat (3) tick();
    Arm = 1'b1; BallSense = 1'b0; repeat (10) tick();
    kick_pulse(); repeat (3) tick();
    BallSense = 1'b1; repeat (10) tick();

    // Abort: Arm low in the second FIRE cycle
    Req = 1'b1; tick();
    Req = 1'b0; tick();
    Arm = 1'b0; tick();
    Arm = 1'b1; repeat (25) tick();
    check("abort_count", {8'd0, KickCount}, 16'd2);

    // Debounce: 3-cycle toggling never settles, a long hold does
    BallSense = 1'b0; repeat (10) tick();
    repeat (6) begin
      BallSense = 1'b1; tick(); tick();
      BallSense = 1'b0; tick();
    end
    check("debounce_glitch", {15'd0, BallPresent}, 16'd0);
    BallSense = 1'b1; repeat (8) tick();
    check("debounce_hold", {15'd0, BallPresent}, 16'd1);

    // Reset mid-WAIT with Req held high throughout
    Req = 1'b1; repeat (7) tick();
    Reset = 1'b1; repeat (2) tick();
    Reset = 1'b0; repeat (15) tick();
    check("reset_no_kick", {8'd0, KickCount}, 16'd0);
    Req = 1'b0; repeat (10) tick();

    // Randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) Req = ~Req;
      Arm = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) BallSense = ~BallSense;
      Reset = ($urandom_range(0, 499) == 0);
      tick();
    end

    // Counter wrap after 256 kicks
    Reset = 1'b1; Req = 1'b0; tick();
    Reset = 1'b0; Arm = 1'b1; BallSense = 1'b1;
    repeat (10) tick();
    repeat (256) begin
      kick_pulse();
      repeat (33) tick();
    end
    check("wrap_count", {8'd0, KickCount}, 16'd0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
